// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - passive I2C bus decoder feeding a record FIFO
// Optional timestamp lane enabled by `define I2C_MON_TIMESTAMP_EN.
module i2c_bus_monitor #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sda_i,
    input  logic        scl_i,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [11:0] evt_data,
    output logic [15:0] evt_ts,
    output logic        busy,
    output logic [7:0]  drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] K_START  = 3'd1;
    localparam logic [2:0] K_RSTART = 3'd2;
    localparam logic [2:0] K_ADDR   = 3'd3;
    localparam logic [2:0] K_DATA   = 3'd4;
    localparam logic [2:0] K_STOP   = 3'd5;
    localparam logic [2:0] K_ERR    = 3'd6;

    typedef enum logic [1:0] {IDLE, BYTE, ACKBIT} state_t;

    logic        sda_q, sda_qq, scl_q, scl_qq;
    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        first_q, first_d;
    logic        hi_q, hi_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        busy_q, busy_d;
    logic [7:0]  drop_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic [11:0] mem_q [FIFO_DEPTH];

    logic        start_c, stop_c, scl_rise, scl_fall;
    logic [3:0]  raw_bits, bits_c;
    logic        at_boundary;
    logic        push_d, push_ok, pop;
    logic [11:0] rec_d;

    assign scl_rise = scl_q & ~scl_qq;
    assign scl_fall = ~scl_q & scl_qq;
    assign start_c  = scl_q & ~sda_q & sda_qq;
    assign stop_c   = scl_q & sda_q & ~sda_qq;

    // The SCL rise that opens a START/STOP condition was shifted as a bit; hi_q discounts it.
    assign raw_bits    = (state_q == ACKBIT) ? 4'd9 : bit_cnt_q;
    assign bits_c      = raw_bits - {3'b000, hi_q};
    assign at_boundary = (state_q == BYTE) && (bits_c == 4'd0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        first_d   = first_q;
        hi_d      = hi_q;
        shreg_d   = shreg_q;
        busy_d    = busy_q;
        push_d    = 1'b0;
        rec_d     = 12'h000;
        if (state_q == IDLE) begin
            if (start_c) begin
                push_d    = 1'b1;
                rec_d     = {K_START, 1'b0, 8'h00};
                busy_d    = 1'b1;
                first_d   = 1'b1;
                bit_cnt_d = 4'd0;
                hi_d      = 1'b0;
                state_d   = BYTE;
            end
        end else if (start_c) begin
            push_d    = 1'b1;
            rec_d     = at_boundary ? {K_RSTART, 1'b0, 8'h00} : {K_ERR, 1'b0, 4'h0, bits_c};
            first_d   = 1'b1;
            bit_cnt_d = 4'd0;
            hi_d      = 1'b0;
            state_d   = BYTE;
        end else if (stop_c) begin
            push_d    = 1'b1;
            rec_d     = at_boundary ? {K_STOP, 1'b0, 8'h00} : {K_ERR, 1'b1, 4'h0, bits_c};
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
            hi_d      = 1'b0;
            state_d   = IDLE;
        end else if (scl_fall) begin
            hi_d = 1'b0;
        end else if (scl_rise) begin
            if (state_q == BYTE) begin
                shreg_d   = {shreg_q[6:0], sda_qq};
                bit_cnt_d = bit_cnt_q + 4'd1;
                hi_d      = 1'b1;
                if (bit_cnt_q == 4'd7)
                    state_d = ACKBIT;
            end else begin
                push_d    = 1'b1;
                rec_d     = {first_q ? K_ADDR : K_DATA, ~sda_qq, shreg_q};
                first_d   = 1'b0;
                bit_cnt_d = 4'd0;
                state_d   = BYTE;
            end
        end
    end

    assign pop     = evt_valid & evt_ready;
    assign push_ok = push_d & ((cnt_q != (AW+1)'(FIFO_DEPTH)) | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_q     <= 1'b1;
            sda_qq    <= 1'b1;
            scl_q     <= 1'b1;
            scl_qq    <= 1'b1;
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            first_q   <= 1'b0;
            hi_q      <= 1'b0;
            shreg_q   <= 8'h00;
            busy_q    <= 1'b0;
            drop_q    <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            sda_q     <= sda_i;
            sda_qq    <= sda_q;
            scl_q     <= scl_i;
            scl_qq    <= scl_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            first_q   <= first_d;
            hi_q      <= hi_d;
            shreg_q   <= shreg_d;
            busy_q    <= busy_d;
            if (push_d && !push_ok && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)
                cnt_q <= cnt_q + 1'b1;
            else if (pop && !push_ok)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= rec_d;
    end

    assign evt_valid = (cnt_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 12'h000;
    assign busy      = busy_q;
    assign drop_cnt  = drop_q;

`ifdef I2C_MON_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] ts_mem_q [FIFO_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ts_q <= 16'h0000;
        else
            ts_q <= ts_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            ts_mem_q[wr_ptr_q] <= ts_q;
    end

    assign evt_ts = evt_valid ? ts_mem_q[rd_ptr_q] : 16'h0000;
`else
    assign evt_ts = 16'h0000;
`endif
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb/tb_i2c_bus_monitor.sv - directed table-driven bench for i2c_bus_monitor
module tb_i2c_bus_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sda = 1'b1;
    logic        scl = 1'b1;
    logic        evt_ready = 1'b1;
    logic        evt_valid;
    logic [11:0] evt_data;
    logic [15:0] evt_ts;
    logic        busy;
    logic [7:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    i2c_bus_monitor #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .sda_i(sda), .scl_i(scl),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .evt_ts(evt_ts), .busy(busy), .drop_cnt(drop_cnt)
    );

    typedef struct {
        int          scen;
        logic [11:0] rec;
        logic [15:0] ts;
    } exp_t;
    exp_t tbl[$];

    logic [11:0] got_d[$];
    logic [15:0] got_t[$];

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            got_d.push_back(evt_data);
            got_t.push_back(evt_ts);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded bound");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int s, input logic [11:0] r, input logic [15:0] t);
        exp_t e;
        e.scen = s;
        e.rec  = r;
        e.ts   = t;
        tbl.push_back(e);
    endtask

    task automatic check_scen(input int s);
        int k = 0;
        foreach (tbl[i]) begin
            if (tbl[i].scen == s) begin
                if (k < got_d.size()) begin
                    check($sformatf("s%0d_rec%0d", s, k), {20'h0, got_d[k]}, {20'h0, tbl[i].rec});
                    check($sformatf("s%0d_ts%0d", s, k), {16'h0, got_t[k]}, {16'h0, tbl[i].ts});
                end
                k++;
            end
        end
        check($sformatf("s%0d_count", s), got_d.size(), k);
        got_d.delete();
        got_t.delete();
    endtask

    task automatic hold();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda = 1'b1; scl = 1'b1; hold();
        sda = 1'b0; hold();
        scl = 1'b0; hold();
    endtask

    task automatic i2c_rstart();
        sda = 1'b1; hold();
        scl = 1'b1; hold();
        sda = 1'b0; hold();
        scl = 1'b0; hold();
    endtask

    task automatic i2c_bit(input logic b);
        sda = b;    hold();
        scl = 1'b1; hold();
        scl = 1'b0; hold();
    endtask

    task automatic i2c_byte(input logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--)
            i2c_bit(d[i]);
        i2c_bit(~ack);
    endtask

    task automatic i2c_stop();
        sda = 1'b0; hold();
        scl = 1'b1; hold();
        sda = 1'b1; hold();
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        add(1, 12'h200, 16'h0); add(1, 12'h784, 16'h0); add(1, 12'h9A5, 16'h0); add(1, 12'hA00, 16'h0);
        add(2, 12'h200, 16'h0); add(2, 12'h784, 16'h0); add(2, 12'h400, 16'h0); add(2, 12'h785, 16'h0);
        add(2, 12'h9A0, 16'h0); add(2, 12'h8A1, 16'h0); add(2, 12'hA00, 16'h0);
        add(3, 12'h200, 16'h0); add(3, 12'h784, 16'h0);
        for (int d = 1; d <= 6; d++)
            add(3, 12'h900 | 12'(d), 16'h0);
        add(4, 12'h200, 16'h0); add(4, 12'h784, 16'h0); add(4, 12'hD03, 16'h0);
        add(6, 12'h200, 16'h0); add(6, 12'h7A1, 16'h0); add(6, 12'hA00, 16'h0);
`ifdef I2C_MON_TIMESTAMP_EN
        add(7, 12'h200, 16'h0010); add(7, 12'hA00, 16'h0038);
`else
        add(7, 12'h200, 16'h0000); add(7, 12'hA00, 16'h0000);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", evt_valid, 0);
        check("rst_data", evt_data, 0);
        check("rst_ts", evt_ts, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        hold();

        // Write transaction with START-latency check
        sda = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("lat_valid_n", evt_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_valid_n1", evt_valid, 1);
        check("lat_busy_n1", busy, 1);
        @(posedge clk); #1;
        hold();
        scl = 1'b0; hold();
        i2c_byte(8'h84, 1'b1);
        i2c_byte(8'hA5, 1'b1);
        i2c_stop();
        settle();
        check("s1_busy_end", busy, 0);
        check_scen(1);

        i2c_start();
        i2c_byte(8'h84, 1'b1);
        i2c_rstart();
        i2c_byte(8'h85, 1'b1);
        i2c_byte(8'hA0, 1'b1);
        i2c_byte(8'hA1, 1'b0);
        i2c_stop();
        settle();
        check_scen(2);

        evt_ready = 1'b0;
        i2c_start();
        i2c_byte(8'h84, 1'b1);
        for (int d = 1; d <= 7; d++)
            i2c_byte(8'(d), 1'b1);
        i2c_stop();
        settle();
        check("ovf_drop", drop_cnt, 2);
        check("ovf_busy", busy, 0);
        check("ovf_valid", evt_valid, 1);
        check("ovf_head_held", evt_data, 12'h200);
        evt_ready = 1'b1;
        settle();
        check("ovf_drained", evt_valid, 0);
        check_scen(3);

        i2c_start();
        i2c_byte(8'h84, 1'b1);
        i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1);
        i2c_stop();
        settle();
        check("err_busy", busy, 0);
        check_scen(4);

        scl = 1'b0; hold();
        sda = 1'b0; hold();
        scl = 1'b1; hold();
        sda = 1'b1; hold();
        settle();
        check("idle_stop_busy", busy, 0);
        check("idle_stop_drop", drop_cnt, 2);
        check_scen(5);

        i2c_start();
        i2c_bit(1'b1); i2c_bit(1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mrst_valid", evt_valid, 0);
        check("mrst_data", evt_data, 0);
        check("mrst_ts", evt_ts, 0);
        check("mrst_busy", busy, 0);
        check("mrst_drop", drop_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        got_d.delete();
        got_t.delete();
        hold();
        i2c_start();
        i2c_byte(8'hA1, 1'b1);
        i2c_stop();
        settle();
        check_scen(6);

        rst = 1'b1;
        sda = 1'b1; scl = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_d.delete();
        got_t.delete();
        repeat (15) @(posedge clk);
        #1;
        sda = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        sda = 1'b1;
        settle();
        check_scen(7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
